// File: rtl/core_pkg.sv
// Shared core types: data word, RV32 load/store funct3 encodings, LSU state and access size.
// The LSU's optional misalignment trap is selected by the LSU_MISALIGN_TRAP_EN macro (see lsu.sv).
package core_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    OP_B  = 3'd0,
    OP_H  = 3'd1,
    OP_W  = 3'd2,
    OP_BU = 3'd4,
    OP_HU = 3'd5
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Unassigned funct3 codes (3, 6, 7) fall through to a full-word access.
  function automatic lsu_size_t op_size(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: return SZ_BYTE;
      OP_H, OP_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [2:0] op);
    return (op == OP_BU) || (op == OP_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalign detect, natural alignment of the low address bits,
// byte enables, store lane replication and load extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_addr_lo,
  input  word_t      i_wdata,
  input  word_t      i_rdata,
  output logic [1:0] o_addr_lo,
  output logic [3:0] o_be,
  output word_t      o_wdata,
  output word_t      o_rdata,
  output logic       o_misalign
);

  lsu_size_t  w_size;
  logic       w_unsigned;
  logic [1:0] w_lo;
  logic [3:0] w_be;
  word_t      w_wdata;
  word_t      w_shift;
  word_t      w_rdata;
  logic       w_misalign;

  assign w_size     = op_size(i_op);
  assign w_unsigned = op_unsigned(i_op);

  always_comb begin
    w_lo       = i_addr_lo;
    w_be       = 4'b1111;
    w_wdata    = i_wdata;
    w_misalign = 1'b0;
    case (w_size)
      SZ_BYTE: begin
        w_lo    = i_addr_lo;
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_misalign = i_addr_lo[0];
        w_lo       = {i_addr_lo[1], 1'b0};
        w_be       = 4'b0011 << {w_lo[1], 1'b0};
        w_wdata    = {2{i_wdata[15:0]}};
      end
      default: begin
        w_misalign = (i_addr_lo != 2'b00);
        w_lo       = 2'b00;
        w_be       = 4'b1111;
        w_wdata    = i_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_shift = i_rdata >> {w_lo, 3'b000};

  always_comb begin
    w_rdata = i_rdata;
    case (w_size)
      SZ_BYTE: w_rdata = w_unsigned ? {24'b0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: w_rdata = w_unsigned ? {16'b0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_rdata = i_rdata;
    endcase
  end

  assign o_addr_lo  = w_lo;
  assign o_be       = w_be;
  assign o_wdata    = w_wdata;
  assign o_rdata    = w_rdata;
  assign o_misalign = w_misalign;

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one op at a time over a req/gnt/rvalid word bus, with response timeout.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses with misalign=1 instead of aligning them.
module lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state
);

  // Bus handshake: mem_req stays high with addr/we/be/wdata frozen until the cycle mem_gnt=1;
  // mem_rvalid is only honoured in WAIT, so a response overlapping the grant cycle is dropped.

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  lsu_state_t  r_state;
  logic [2:0]  r_op;
  logic        r_is_store;
  logic [1:0]  r_addr_lo;
  logic [7:0]  r_cnt;
  logic        r_ready;
  logic        r_done;
  word_t       r_result;
  logic        r_misalign;
  logic        r_bus_err;
  logic        r_mem_req;
  logic [29:0] r_mem_addr;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  word_t       r_mem_wdata;

  logic        w_in_idle;
  logic [2:0]  w_al_op;
  logic [1:0]  w_al_lo;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  word_t       w_wdata;
  word_t       w_rdata;
  logic        w_misalign;
  logic        w_trap;
  logic [7:0]  w_cnt_next;

  // One aligner serves both issue (live inputs) and writeback (latched op/offset).
  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_al_op    = w_in_idle ? op : r_op;
  assign w_al_lo    = w_in_idle ? addr[1:0] : r_addr_lo;
  assign w_trap     = TRAP_EN & w_misalign;
  assign w_cnt_next = r_cnt + 8'd1;

  lsu_align u_align (
    .i_op       (w_al_op),
    .i_addr_lo  (w_al_lo),
    .i_wdata    (wdata),
    .i_rdata    (mem_rdata),
    .o_addr_lo  (w_addr_lo),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_is_store  <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_cnt       <= 8'd0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op       <= op;
            r_is_store <= is_store;
            r_addr_lo  <= w_addr_lo;
            r_cnt      <= 8'd0;
            r_ready    <= 1'b0;
            if (w_trap) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_result   <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= addr[31:2];
              r_mem_we    <= is_store;
              r_mem_be    <= w_be;
              r_mem_wdata <= is_store ? w_wdata : '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_state     <= ST_WAIT;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
          end
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_next;
          if (mem_rvalid) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= r_is_store ? '0 : w_rdata;
          end else if (w_cnt_next == TO_LIMIT) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_result  <= '0;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_ready    <= 1'b1;
          r_result   <= '0;
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign result    = r_result;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan steps, then randomized ops against a byte-level model.
module tb_lsu;
  import core_pkg::*;

  localparam int TO = 255;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_store(is_store),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .result(result),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---- reference model: access described as a byte count and a byte offset ----
  function automatic int unsigned op_bytes(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd4) return 1;
    if (o == 3'd1 || o == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int unsigned eff_off(input logic [2:0] o, input logic [31:0] a);
    int unsigned nb = op_bytes(o);
    return (a - (a % nb)) % 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] o, input logic [31:0] a);
    int unsigned nb = op_bytes(o);
    int unsigned off = eff_off(o, a);
    logic [3:0] be = '0;
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] o, input logic [31:0] wd);
    int unsigned nb = op_bytes(o);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] rd);
    int unsigned nb = op_bytes(o);
    int unsigned off = eff_off(o, a);
    logic [31:0] v = rd >> (8 * off);
    logic [31:0] mask;
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if ((o == 3'd0 || o == 3'd1) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- driver: issues one op after a negedge with the LSU idle, checks everything on the way ----
  task automatic do_op(input logic [2:0] o, input logic st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int gw, input int rw, input bit rv_in_req);
    int unsigned nb = op_bytes(o);
    bit mis = (a % nb) != 0;
    logic [3:0]  e_be = model_be(o, a);
    logic [31:0] e_wd = model_wdata(o, wd);
    logic [31:0] e_res = st ? 32'd0 : model_load(o, a, rd);
    check("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1; op = o; is_store = st; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    if (TRAP && mis) begin
      check("trap_done", 32'(done), 32'd1);
      check("trap_misalign", 32'(misalign), 32'd1);
      check("trap_result", result, 32'd0);
      check("trap_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("trap_ready_after", 32'(ready), 32'd1);
      return;
    end
    for (int g = 0; g <= gw; g++) begin
      check("req_high", 32'(mem_req), 32'd1);
      check("req_addr", 32'(mem_addr), {2'b00, a[31:2]});
      check("req_be", 32'(mem_be), 32'(e_be));
      check("req_we", 32'(mem_we), 32'(st));
      if (st) check("req_wdata", mem_wdata, e_wd);
      start = 1'b1; op = 3'($urandom_range(0, 7)); is_store = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      mem_gnt = (g == gw);
      mem_rvalid = (g == gw) && rv_in_req;
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int r = 0; r <= rw; r++) begin
      check("wait_req_low", 32'(mem_req), 32'd0);
      check("wait_no_done", 32'(done), 32'd0);
      start = 1'($urandom);
      mem_rvalid = (r == rw);
      mem_rdata = (r == rw) ? rd : $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b0; start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_result", result, e_res);
    check("done_bus_err", 32'(bus_err), 32'd0);
    check("done_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [2:0] st_ops [6];
    int k;
    st_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0; start = 1'b0; op = '0; is_store = 1'b0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Directed test-plan steps
    do_op(3'd2, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    do_op(3'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(3'd4, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(3'd1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 1'b0);
    do_op(3'd1, 1'b1, 32'h102, 32'h5678, 32'h0, 0, 0, 1'b0);
    do_op(3'd2, 1'b0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 5, 2, 1'b1);
    do_op(3'd2, 1'b0, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 1'b0);
    do_op(3'd5, 1'b1, 32'h203, 32'hA5A5_1357, 32'h0, 1, 0, 1'b0);

    // Timeout: granted load with no response
    start = 1'b1; op = 3'd2; is_store = 1'b0; addr = 32'h400; wdata = '0;
    @(negedge clk);
    start = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TO));
    check("timeout_done", 32'(done), 32'd1);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    check("timeout_result", result, 32'd0);
    @(negedge clk);
    check("timeout_ready", 32'(ready), 32'd1);

    // Reset while waiting for a response; a late response must be ignored
    start = 1'b1; op = 3'd2; is_store = 1'b0; addr = 32'h800;
    @(negedge clk);
    start = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("midrst_no_done", 32'(done), 32'd0);
    @(negedge clk);
    check("midrst_no_done2", 32'(done), 32'd0);
    check("midrst_ready2", 32'(ready), 32'd1);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic st;
      logic [2:0] o;
      st = 1'($urandom);
      o = st ? st_ops[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      do_op(o, st, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue RV32I core; sits directly downstream of the execute ALU and consumes its `ADD` result as the effective address. It accepts one memory op at a time, runs a request/grant/response handshake on a 32-bit word-addressed data bus, steers byte lanes for stores, and aligns and extends load data for writeback. Completion is a one-cycle `done` pulse the core stalls on.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles in WAIT with no `mem_rvalid` before `bus_err` is flagged; 8-bit counter.

Ports:
- `clk`  in  1  core clock; the only clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  issue strobe; sampled only when `ready`=1
- `op`  in  3  `lsu_op_t` in RV32 funct3 encoding: LB=0, LH=1, LW=2, LBU=4, LHU=5; `is_store` selects SB/SH/SW
- `is_store`  in  1  1=store, 0=load
- `addr`  in  32  effective address (ALU output)
- `wdata`  in  32  store data (rs2)
- `ready`  out  1  idle, can accept `start`
- `done`  out  1  one-cycle completion pulse
- `result`  out  32  extended load data, valid while `done`=1; 0 for stores
- `misalign`  out  1  with `done`: access was misaligned (trap config only)
- `bus_err`  out  1  with `done`: response timed out
- `mem_req`  out  1  bus request
- `mem_gnt`  in  1  bus accepted request this cycle
- `mem_addr`  out  30  word address, `addr[31:2]`
- `mem_we`  out  1  write enable
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-steered store data
- `mem_rvalid`  in  1  response (read data or write ack)
- `mem_rdata`  in  32  read data, valid with `mem_rvalid`

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `ready`=1. `start` latches op, is_store, addr, wdata into registers -> REQ. If misaligned and trap enabled -> DONE directly, no bus access.
- REQ: `mem_req`=1 with registered addr/we/be/wdata held stable; `mem_gnt`=1 -> WAIT. Request never withdrawn until granted.
- WAIT: `mem_req`=0; timeout counter increments per cycle; `mem_rvalid` -> DONE, latching aligned/extended result. Counter reaching `TIMEOUT_CYCLES` -> DONE with `bus_err`=1, `result`=0.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `mem_gnt` and `mem_rvalid` in the same REQ cycle: grant accepted only; response ignored outside WAIT.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<{addr[1],1'b0}`; word `4'b1111`.
- Store data replicated across lanes: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`.
- Load: select lane by `addr[1:0]`, sign-extend for LB/LH, zero-extend for LBU/LHU.
- Misaligned: half with `addr[0]`=1, word with `addr[1:0]`≠0.
- Undefined `op` (3, 6, 7): treated as LW/SW.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): state IDLE; `ready`=1; `done`, `misalign`, `bus_err`, `mem_req`, `mem_we`=0; `mem_be`=0; `result`, `mem_addr`, `mem_wdata`=0; counter 0. Reset mid-transaction abandons it; late `mem_rvalid` after reset is ignored (IDLE).
- Best case: `start` at cycle 0, `mem_req` cycle 1 with `mem_gnt`, `mem_rvalid` cycle 2, `done` cycle 3, `ready` again cycle 4. Latency = 3 + grant wait + response wait.
- Trap path: `start` cycle 0 -> `done`+`misalign` cycle 1.
- All outputs registered.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned access skips the bus, completes with `misalign`=1, `result`=0.
- Undefined: `misalign` tied 0; `addr` low bits forced to natural alignment (half: `addr[0]`=0; word: `addr[1:0]`=0) and the access proceeds normally.

## Structure
- Shared package `core_pkg`: `word_t`, `lsu_op_t` enum, LSU state enum.
- Sub-module `lsu_align` (combinational): byte-enable generation, store lane steering, load extraction/extension, misalign detect. The FSM, registers and timeout live in `lsu`.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, immediate gnt/rvalid -> `mem_addr`=0x40, `mem_be`=4'hF, `mem_we`=1, `done` at cycle 3.
- LB addr=0x103, `mem_rdata`=0x80FF_0000 -> `result`=0xFFFFFF80; LBU same -> 0x00000080.
- LH addr=0x102, `mem_rdata`=0x8001_1234 -> `result`=0xFFFF8001; SH addr=0x102, wdata=0x5678 -> `mem_be`=4'b1100, `mem_wdata`=0x56785678.
- `mem_gnt` held low 5 cycles -> `mem_req` and all bus fields stable throughout; `start` pulses during busy ignored.
- LW addr=0x101: with `LSU_MISALIGN_TRAP_EN` -> `done`+`misalign` at cycle 1, no `mem_req`; without -> `mem_addr`=0x40, normal load.
- No `mem_rvalid` -> `bus_err`+`done` after `TIMEOUT_CYCLES`; `rst_n`=0 in WAIT -> IDLE next edge, later `mem_rvalid` produces no `done`.
